// File: rtl/program_loader.sv
// Byte-stream instruction-memory loader: frames count / big-endian words / XOR checksum,
// writes consecutive words, then releases the processor from reset on a good checksum.
//
// state | meaning
// IDLE  | waiting for Start after reset
// COUNT | accepting the word-count byte N
// HI    | accepting the high byte of the next word
// LO    | accepting the low byte; assembles the word
// WRITE | one-cycle instruction-memory write
// CHECK | accepting and comparing the checksum byte
// DONE  | load good, processor released
// ERR   | load rejected, processor held in reset
module program_loader #(
  parameter int ADDR_W    = 7,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [15:0]       IM_Data,
  output logic              CPU_Reset,
  output logic              Done,
  output logic              Error,
  output logic [3:0]        State
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    COUNT = 4'd1,
    HI    = 4'd2,
    LO    = 4'd3,
    WRITE = 4'd4,
    CHECK = 4'd5,
    DONE  = 4'd6,
    ERR   = 4'd7
  } state_t;

  // The count byte is 8 bits wide, so the address is zero-extended to a byte for compares.
  localparam int         PAD   = 8 - ADDR_W;
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [7:0]        count_q;
  logic [7:0]        csum_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;

  logic       xfer;
  logic       count_bad;
  logic       last_word;
  logic [7:0] last_idx;

  assign xfer      = in_valid && in_ready;
  assign count_bad = (in_data == 8'd0) || (in_data > MAX_N);
  assign last_idx  = count_q - 8'd1;
  assign last_word = ({{PAD{1'b0}}, addr_q} == last_idx);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (Start) state_d = COUNT;
      COUNT: if (xfer)  state_d = count_bad ? ERR : HI;
      HI:    if (xfer)  state_d = LO;
      LO:    if (xfer)  state_d = WRITE;
      WRITE: state_d = last_word ? CHECK : HI;
      CHECK: if (xfer)  state_d = (in_data == csum_q) ? DONE : ERR;
      DONE:  if (Start) state_d = COUNT;
      ERR:   if (Start) state_d = COUNT;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; reset lands in IDLE so these follow Reset without a clock edge.
  always_comb begin
    in_ready  = 1'b0;
    IM_Wr     = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    CPU_Reset = 1'b1;
    case (state_q)
      COUNT, HI, LO, CHECK: in_ready = 1'b1;
      WRITE:                IM_Wr    = 1'b1;
      DONE: begin
        Done      = 1'b1;
        CPU_Reset = 1'b0;
      end
      ERR:                  Error    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q <= 8'd0;
      csum_q  <= 8'd0;
      hi_q    <= 8'd0;
      addr_q  <= '0;
      data_q  <= 16'd0;
    end else begin
      case (state_q)
        COUNT: if (xfer) begin
          count_q <= in_data;
          csum_q  <= in_data;
          addr_q  <= '0;
        end
        HI: if (xfer) begin
          hi_q   <= in_data;
          csum_q <= csum_q ^ in_data;
        end
        LO: if (xfer) begin
          data_q <= {hi_q, in_data};
          csum_q <= csum_q ^ in_data;
        end
        WRITE: if (!last_word) addr_q <= addr_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign IM_Addr = addr_q;
  assign IM_Data = data_q;
  assign State   = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level reference model.
module tb_program_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [22:0] wr_t;
  typedef wr_t         wr_q_t[$];

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        IM_Wr;
  logic [6:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic        CPU_Reset;
  logic        Done;
  logic        Error;
  logic [3:0]  State;

  int checks = 0;
  int errors = 0;

  wr_q_t wr_q;
  int    dbl_wr = 0;
  bit    prev_wr = 1'b0;

  program_loader #(.ADDR_W(7), .MAX_WORDS(128)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .IM_Wr(IM_Wr), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
    .CPU_Reset(CPU_Reset), .Done(Done), .Error(Error), .State(State)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (IM_Wr === 1'b1) begin
      wr_q.push_back({IM_Addr, IM_Data});
      if (prev_wr) dbl_wr++;
    end
    prev_wr = (IM_Wr === 1'b1);
  end

  // Reference model: outcome and write list derived from the frame bytes alone.
  task automatic model(input byte_q_t fr, output wr_q_t exp_w, output bit exp_done);
    int n;
    logic [7:0] x;
    exp_w = {};
    exp_done = 1'b0;
    n = int'(fr[0]);
    if (n == 0 || n > 128) return;
    x = fr[0];
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({7'(i), fr[1 + 2*i], fr[2 + 2*i]});
      x = x ^ fr[1 + 2*i] ^ fr[2 + 2*i];
    end
    exp_done = (fr[2*n + 1] == x);
  endtask

  task automatic make_frame(input int n, input int corrupt, output byte_q_t fr);
    logic [7:0] x;
    logic [7:0] b;
    fr = {};
    fr.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < 2*n; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      x = x ^ b;
    end
    fr.push_back(x ^ 8'(corrupt));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic run_frame(input byte_q_t fr, input int gap_pct, input int stop_wr,
                           output int cycles, output bit timeout, output bit rst_first);
    int idx;
    int nwr;
    bit rdy;
    bit first;
    idx = 0; nwr = 0; first = 1'b1;
    cycles = 0; timeout = 1'b1; rst_first = 1'b0;
    @(negedge clk);
    Start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      in_valid = (idx < fr.size()) && ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? fr[idx] : 8'($urandom);
      rdy = in_ready;
      @(posedge clk);
      cycles++;
      if (in_valid && rdy) idx++;
      @(negedge clk);
      Start = 1'b0;
      if (first) begin rst_first = CPU_Reset; first = 1'b0; end
      if (IM_Wr === 1'b1) nwr++;
      if (stop_wr > 0 && nwr >= stop_wr) begin timeout = 1'b0; break; end
      if (State == 4'd6 || State == 4'd7) begin timeout = 1'b0; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b1;
    #1;
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", State); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (IM_Wr !== 1'b0) begin errors++; $display("FAIL reset_im_wr got %b want 0", IM_Wr); end
    checks++; if (IM_Addr !== 7'd0) begin errors++; $display("FAIL reset_im_addr got %0d want 0", IM_Addr); end
    checks++; if (IM_Data !== 16'd0) begin errors++; $display("FAIL reset_im_data got %h want 0", IM_Data); end
    checks++; if (CPU_Reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got %b want 1", CPU_Reset); end
    checks++; if (Done !== 1'b0 || Error !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b want 00", Done, Error); end
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_good_load();
    byte_q_t fr;
    wr_q_t exp_w;
    bit exp_done, to, rh;
    int cyc;
    apply_reset();
    fr = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    model(fr, exp_w, exp_done);
    wr_q.delete();
    run_frame(fr, 0, 0, cyc, to, rh);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL good_timeout got timeout want finish"); end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL good_latency got %0d want 9", cyc); end
    checks++; if (State !== (exp_done ? 4'd6 : 4'd7)) begin errors++; $display("FAIL good_state got %0d want %0d", State, exp_done ? 6 : 7); end
    checks++; if (Done !== 1'b1 || CPU_Reset !== 1'b0 || Error !== 1'b0) begin errors++; $display("FAIL good_outputs got done=%b cpu_rst=%b err=%b want 1 0 0", Done, CPU_Reset, Error); end
    checks++; if (wr_q.size() !== exp_w.size()) begin errors++; $display("FAIL good_nwrites got %0d want %0d", wr_q.size(), exp_w.size()); end
    for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++) begin
      checks++; if (wr_q[i] !== exp_w[i]) begin errors++; $display("FAIL good_write[%0d] got %h want %h", i, wr_q[i], exp_w[i]); end
    end
  endtask

  task automatic test_bad_checksum();
    byte_q_t fr;
    wr_q_t exp_w;
    bit exp_done, to, rh;
    int cyc;
    apply_reset();
    fr = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    model(fr, exp_w, exp_done);
    wr_q.delete();
    run_frame(fr, 0, 0, cyc, to, rh);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL badsum_timeout got timeout want finish"); end
    checks++; if (State !== (exp_done ? 4'd6 : 4'd7)) begin errors++; $display("FAIL badsum_state got %0d want %0d", State, exp_done ? 6 : 7); end
    checks++; if (Error !== 1'b1 || CPU_Reset !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL badsum_outputs got err=%b cpu_rst=%b done=%b want 1 1 0", Error, CPU_Reset, Done); end
    checks++; if (wr_q.size() !== exp_w.size()) begin errors++; $display("FAIL badsum_nwrites got %0d want %0d", wr_q.size(), exp_w.size()); end
    for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++) begin
      checks++; if (wr_q[i] !== exp_w[i]) begin errors++; $display("FAIL badsum_write[%0d] got %h want %h", i, wr_q[i], exp_w[i]); end
    end
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    checks++; if (Error !== 1'b0 || State !== 4'd1) begin errors++; $display("FAIL badsum_restart got err=%b state=%0d want 0 1", Error, State); end
  endtask

  task automatic test_illegal_count();
    byte_q_t fr;
    bit to, rh;
    int cyc;
    logic [7:0] cnt [2];
    cnt[0] = 8'h00;
    cnt[1] = 8'h81;
    for (int t = 0; t < 2; t++) begin
      apply_reset();
      fr = {cnt[t], 8'h11, 8'h22, 8'h33};
      wr_q.delete();
      run_frame(fr, 0, 0, cyc, to, rh);
      checks++; if (to !== 1'b0 || State !== 4'd7) begin errors++; $display("FAIL illegal_%h_state got %0d want 7", cnt[t], State); end
      checks++; if (Error !== 1'b1 || CPU_Reset !== 1'b1) begin errors++; $display("FAIL illegal_%h_outputs got err=%b cpu_rst=%b want 1 1", cnt[t], Error, CPU_Reset); end
      checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL illegal_%h_nwrites got %0d want 0", cnt[t], wr_q.size()); end
    end
  endtask

  task automatic test_full_depth();
    byte_q_t fr;
    wr_q_t exp_w;
    bit exp_done, to, rh;
    int cyc;
    int bad;
    apply_reset();
    make_frame(128, 0, fr);
    model(fr, exp_w, exp_done);
    wr_q.delete();
    dbl_wr = 0;
    run_frame(fr, 30, 0, cyc, to, rh);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL full_timeout got timeout want finish"); end
    checks++; if (State !== (exp_done ? 4'd6 : 4'd7)) begin errors++; $display("FAIL full_state got %0d want %0d", State, exp_done ? 6 : 7); end
    checks++; if (wr_q.size() !== exp_w.size()) begin errors++; $display("FAIL full_nwrites got %0d want %0d", wr_q.size(), exp_w.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_w[i]) begin
        errors++;
        if (bad < 5) $display("FAIL full_write[%0d] got %h want %h", i, wr_q[i], exp_w[i]);
        bad++;
      end
    end
    checks++; if (dbl_wr !== 0) begin errors++; $display("FAIL full_consecutive_wr got %0d want 0", dbl_wr); end
  endtask

  task automatic test_reset_during_load();
    byte_q_t fr;
    wr_q_t exp_w;
    bit exp_done, to, rh;
    int cyc;
    apply_reset();
    make_frame(3, 0, fr);
    wr_q.delete();
    run_frame(fr, 0, 1, cyc, to, rh);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_timeout got timeout want first write"); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (State !== 4'd0 || CPU_Reset !== 1'b1) begin errors++; $display("FAIL midrst_state got %0d cpu_rst=%b want 0 1", State, CPU_Reset); end
    checks++; if (IM_Wr !== 1'b0 || in_ready !== 1'b0 || IM_Addr !== 7'd0) begin errors++; $display("FAIL midrst_outputs got wr=%b rdy=%b addr=%0d want 0 0 0", IM_Wr, in_ready, IM_Addr); end
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL midrst_nwrites got %0d want 1", wr_q.size()); end
    @(negedge clk);
    Reset = 1'b0;
    fr = {8'h01, 8'hBE, 8'hEF, 8'h50};
    model(fr, exp_w, exp_done);
    wr_q.delete();
    run_frame(fr, 0, 0, cyc, to, rh);
    checks++; if (to !== 1'b0 || State !== (exp_done ? 4'd6 : 4'd7)) begin errors++; $display("FAIL reload_state got %0d want %0d", State, exp_done ? 6 : 7); end
    checks++; if (wr_q.size() !== 1 || wr_q.size() !== exp_w.size()) begin errors++; $display("FAIL reload_nwrites got %0d want %0d", wr_q.size(), exp_w.size()); end
    else begin
      checks++; if (wr_q[0] !== exp_w[0]) begin errors++; $display("FAIL reload_write got %h want %h", wr_q[0], exp_w[0]); end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t fr;
    wr_q_t exp_w;
    bit exp_done, to, rh;
    int cyc, r, n, corrupt;
    apply_reset();
    for (int f = 0; f < 8; f++) begin
      r = $urandom_range(9);
      if (r == 0) begin
        n = ($urandom_range(1) == 0) ? 0 : $urandom_range(255, 129);
        fr = {8'(n)};
      end else begin
        n = $urandom_range(6, 1);
        corrupt = (r < 4) ? $urandom_range(255, 1) : 0;
        make_frame(n, corrupt, fr);
      end
      model(fr, exp_w, exp_done);
      wr_q.delete();
      run_frame(fr, 20, 0, cyc, to, rh);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b[%0d]_timeout got timeout want finish", f); end
      checks++; if (rh !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_cpu_reset_on_reload got %b want 1", f, rh); end
      checks++; if (State !== (exp_done ? 4'd6 : 4'd7) || Done !== exp_done || Error !== !exp_done) begin errors++; $display("FAIL b2b[%0d]_outcome got state=%0d done=%b err=%b want done=%b", f, State, Done, Error, exp_done); end
      checks++; if (wr_q.size() !== exp_w.size()) begin errors++; $display("FAIL b2b[%0d]_nwrites got %0d want %0d", f, wr_q.size(), exp_w.size()); end
      for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++) begin
        checks++; if (wr_q[i] !== exp_w[i]) begin errors++; $display("FAIL b2b[%0d]_write[%0d] got %h want %h", f, i, wr_q[i], exp_w[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_illegal_count();
    test_full_depth();
    test_reset_during_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
